// File: rtl/counter_sequencer.sv
// Sequencer for a chain of 4-bit counters: shared tick prescaler, go/pause
// handshakes to the active counter, done chaining and display mux.
module counter_sequencer #(
    parameter int unsigned N_CNT   = 2,
    parameter int unsigned DIV_W   = 24,
    parameter int unsigned DIV_MAX = 5999999,
    parameter int unsigned LOOP    = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_btn,
    input  logic               pause_btn,
    input  logic [N_CNT-1:0]   cnt_done,
    input  logic [4*N_CNT-1:0] cnt_out,
    output logic               tick,
    output logic [N_CNT-1:0]   go,
    output logic [N_CNT-1:0]   pause,
    output logic [2:0]         active_idx,
    output logic [3:0]         disp,
    output logic               running,
    output logic               paused,
    output logic               seq_done,
    output logic [7:0]         laps
);

    localparam int unsigned IDX_W  = 3;
    localparam int unsigned LAPS_W = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                tick_q, tick_d;
    logic                start_prev_q, start_prev_d;
    logic                pause_prev_q, pause_prev_d;
    logic                done_prev_q, done_prev_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [N_CNT-1:0]    go_q, go_d;
    logic [N_CNT-1:0]    pause_vec_q, pause_vec_d;
    logic                seq_done_q, seq_done_d;
    logic [LAPS_W-1:0]   laps_q, laps_d;
    logic                running_q, running_d;
    logic                paused_q, paused_d;

    logic                done_sel_c;
    logic                done_next_c;
    logic                start_rise_c;
    logic                pause_rise_c;
    logic                done_rise_c;

    // Prescaler: free-running; tick registered so it is high while count == DIV_MAX
    always_comb begin
        div_d  = (div_q == DIV_W'(DIV_MAX)) ? '0 : div_q + DIV_W'(1);
        tick_d = (div_d == DIV_W'(DIV_MAX));
    end

    // Done bit of the currently active counter
    always_comb begin
        done_sel_c = 1'b0;
        for (int unsigned i = 0; i < N_CNT; i++) begin
            if (idx_q == IDX_W'(i)) begin
                done_sel_c = cnt_done[i];
            end
        end
    end

    // Done bit of the counter that will be active next cycle; preloads the
    // edge register on a switch so a stale high done cannot fire
    always_comb begin
        done_next_c = 1'b0;
        for (int unsigned i = 0; i < N_CNT; i++) begin
            if (idx_d == IDX_W'(i)) begin
                done_next_c = cnt_done[i];
            end
        end
    end

    assign start_rise_c = start_btn & ~start_prev_q;
    assign pause_rise_c = pause_btn & ~pause_prev_q;
    assign done_rise_c  = done_sel_c & ~done_prev_q;

    always_comb begin
        start_prev_d = start_btn;
        pause_prev_d = pause_btn;
        done_prev_d  = done_next_c;
    end

    // Next-state and pulse generation
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        go_d        = '0;
        pause_vec_d = '0;
        seq_done_d  = 1'b0;
        laps_d      = laps_q;

        case (state_q)
            S_IDLE: begin
                if (start_rise_c) begin
                    idx_d   = '0;
                    go_d    = N_CNT'(1);
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // A done rise takes priority; a coincident pause press is dropped
                if (done_rise_c) begin
                    if (idx_q == IDX_W'(N_CNT - 1)) begin
                        if (LOOP != 0) begin
                            idx_d  = '0;
                            go_d   = N_CNT'(1);
                            laps_d = laps_q + LAPS_W'(1);
                        end else begin
                            seq_done_d = 1'b1;
                            state_d    = S_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        go_d  = N_CNT'(1) << idx_d;
                    end
                end else if (pause_rise_c) begin
                    pause_vec_d = N_CNT'(1) << idx_q;
                    state_d     = S_PAUSED;
                end
            end
            S_PAUSED: begin
                if (pause_rise_c) begin
                    pause_vec_d = N_CNT'(1) << idx_q;
                    state_d     = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        running_d = (state_d == S_RUN) || (state_d == S_PAUSED);
        paused_d  = (state_d == S_PAUSED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            div_q        <= '0;
            tick_q       <= 1'b0;
            start_prev_q <= 1'b0;
            pause_prev_q <= 1'b0;
            done_prev_q  <= 1'b0;
            idx_q        <= '0;
            go_q         <= '0;
            pause_vec_q  <= '0;
            seq_done_q   <= 1'b0;
            laps_q       <= '0;
            running_q    <= 1'b0;
            paused_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            tick_q       <= tick_d;
            start_prev_q <= start_prev_d;
            pause_prev_q <= pause_prev_d;
            done_prev_q  <= done_prev_d;
            idx_q        <= idx_d;
            go_q         <= go_d;
            pause_vec_q  <= pause_vec_d;
            seq_done_q   <= seq_done_d;
            laps_q       <= laps_d;
            running_q    <= running_d;
            paused_q     <= paused_d;
        end
    end

    // Display follows the active counter, including after completion
    always_comb begin
        disp = 4'h0;
        for (int unsigned i = 0; i < N_CNT; i++) begin
            if (idx_q == IDX_W'(i)) begin
                disp = cnt_out[4*i +: 4];
            end
        end
    end

    assign tick       = tick_q;
    assign go         = go_q;
    assign pause      = pause_vec_q;
    assign active_idx = idx_q;
    assign running    = running_q;
    assign paused     = paused_q;
    assign seq_done   = seq_done_q;
    assign laps       = laps_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer: one stop-mode instance and one loop-mode instance.
module tb_counter_sequencer;

    logic       clk;
    logic       rst;
    logic       start_btn, pause_btn;
    logic [1:0] cnt_done;
    logic [7:0] cnt_out;
    logic       tick, running, paused, seq_done;
    logic [1:0] go, pause;
    logic [2:0] active_idx;
    logic [3:0] disp;
    logic [7:0] laps;

    logic       l_start, l_pause;
    logic [1:0] l_done;
    logic [7:0] l_out;
    logic       l_tick, l_running, l_paused, l_seq_done;
    logic [1:0] l_go, l_pause_o;
    logic [2:0] l_idx;
    logic [3:0] l_disp;
    logic [7:0] l_laps;

    int errors = 0;
    int checks = 0;

    counter_sequencer #(.N_CNT(2), .DIV_W(4), .DIV_MAX(3), .LOOP(0)) dut (
        .clk(clk), .rst(rst), .start_btn(start_btn), .pause_btn(pause_btn),
        .cnt_done(cnt_done), .cnt_out(cnt_out), .tick(tick), .go(go),
        .pause(pause), .active_idx(active_idx), .disp(disp), .running(running),
        .paused(paused), .seq_done(seq_done), .laps(laps)
    );

    counter_sequencer #(.N_CNT(2), .DIV_W(4), .DIV_MAX(3), .LOOP(1)) dut_loop (
        .clk(clk), .rst(rst), .start_btn(l_start), .pause_btn(l_pause),
        .cnt_done(l_done), .cnt_out(l_out), .tick(l_tick), .go(l_go),
        .pause(l_pause_o), .active_idx(l_idx), .disp(l_disp), .running(l_running),
        .paused(l_paused), .seq_done(l_seq_done), .laps(l_laps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if ({tick, go, pause, active_idx, running, paused, seq_done, laps} !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {tick, go, pause, active_idx, running, paused, seq_done, laps});
        end
        checks++;
        if ({l_go, l_idx, l_running, l_laps} !== 15'h0) begin
            errors++;
            $display("FAIL reset_loop_outputs got=%h exp=0", {l_go, l_idx, l_running, l_laps});
        end
    endtask

    task automatic test_tick();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            checks++;
            if (tick !== ((c % 4) == 3)) begin
                errors++;
                $display("FAIL tick_cycle%0d got=%b exp=%b", c, tick, ((c % 4) == 3));
            end
            step();
        end
    endtask

    task automatic test_start();
        int extra_go;
        extra_go = 0;
        start_btn = 1'b1;
        step();
        checks++;
        if ({go, running, active_idx} !== {2'b01, 1'b1, 3'd0}) begin
            errors++;
            $display("FAIL start_go got go=%b run=%b idx=%0d exp go=01 run=1 idx=0",
                     go, running, active_idx);
        end
        step();
        checks++;
        if (go !== 2'b00) begin
            errors++;
            $display("FAIL start_go_width got=%b exp=00", go);
        end
        for (int i = 0; i < 20; i++) begin
            step();
            if (go !== 2'b00) extra_go++;
        end
        checks++;
        if (extra_go !== 0) begin
            errors++;
            $display("FAIL start_held_retrigger got=%0d exp=0", extra_go);
        end
        start_btn = 1'b0;
        step();
    endtask

    task automatic test_chain();
        cnt_out = 8'h95;
        #1;
        checks++;
        if (disp !== 4'h5) begin
            errors++;
            $display("FAIL chain_disp0 got=%h exp=5", disp);
        end
        cnt_done = 2'b01;
        step();
        checks++;
        if ({go, active_idx, disp} !== {2'b10, 3'd1, 4'h9}) begin
            errors++;
            $display("FAIL chain_go1 got go=%b idx=%0d disp=%h exp go=10 idx=1 disp=9",
                     go, active_idx, disp);
        end
        step();
        cnt_done = 2'b11;
        step();
        checks++;
        if ({seq_done, running, active_idx} !== {1'b1, 1'b0, 3'd1}) begin
            errors++;
            $display("FAIL chain_seq_done got sd=%b run=%b idx=%0d exp sd=1 run=0 idx=1",
                     seq_done, running, active_idx);
        end
        step();
        checks++;
        if ({seq_done, disp} !== {1'b0, 4'h9}) begin
            errors++;
            $display("FAIL chain_after_done got sd=%b disp=%h exp sd=0 disp=9", seq_done, disp);
        end
        cnt_done = 2'b00;
        step();
    endtask

    task automatic test_stale_done();
        start_btn = 1'b1;
        step();
        start_btn = 1'b0;
        cnt_done  = 2'b10;
        step();
        checks++;
        if ({go, active_idx} !== {2'b00, 3'd0}) begin
            errors++;
            $display("FAIL stale_nonactive got go=%b idx=%0d exp go=00 idx=0", go, active_idx);
        end
        cnt_done = 2'b11;
        step();
        checks++;
        if ({go, active_idx} !== {2'b10, 3'd1}) begin
            errors++;
            $display("FAIL stale_switch got go=%b idx=%0d exp go=10 idx=1", go, active_idx);
        end
        step();
        checks++;
        if ({seq_done, running} !== 2'b01) begin
            errors++;
            $display("FAIL stale_high_done got sd=%b run=%b exp sd=0 run=1", seq_done, running);
        end
        cnt_done = 2'b01;
        step();
        cnt_done = 2'b11;
        step();
        checks++;
        if (seq_done !== 1'b1) begin
            errors++;
            $display("FAIL stale_real_done got=%b exp=1", seq_done);
        end
        cnt_done = 2'b00;
        step();
    endtask

    task automatic test_pause();
        pause_btn = 1'b1;
        step();
        checks++;
        if ({pause, paused, running} !== 4'b0000) begin
            errors++;
            $display("FAIL pause_in_idle got pause=%b pd=%b run=%b exp all 0", pause, paused, running);
        end
        pause_btn = 1'b0;
        step();
        start_btn = 1'b1;
        step();
        start_btn = 1'b0;
        cnt_done  = 2'b01;
        step();
        pause_btn = 1'b1;
        step();
        checks++;
        if ({pause, paused, go} !== {2'b10, 1'b1, 2'b00}) begin
            errors++;
            $display("FAIL pause_press got pause=%b pd=%b go=%b exp pause=10 pd=1 go=00",
                     pause, paused, go);
        end
        step();
        checks++;
        if ({pause, paused} !== {2'b00, 1'b1}) begin
            errors++;
            $display("FAIL pause_width got pause=%b pd=%b exp pause=00 pd=1", pause, paused);
        end
        pause_btn = 1'b0;
        cnt_done  = 2'b11;
        step();
        checks++;
        if ({seq_done, paused} !== 2'b01) begin
            errors++;
            $display("FAIL pause_done_ignored got sd=%b pd=%b exp sd=0 pd=1", seq_done, paused);
        end
        pause_btn = 1'b1;
        step();
        checks++;
        if ({pause, paused, running} !== {2'b10, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL pause_resume got pause=%b pd=%b run=%b exp pause=10 pd=0 run=1",
                     pause, paused, running);
        end
        pause_btn = 1'b0;
        cnt_done  = 2'b01;
        step();
        cnt_done = 2'b11;
        step();
        checks++;
        if (seq_done !== 1'b1) begin
            errors++;
            $display("FAIL pause_then_done got=%b exp=1", seq_done);
        end
        cnt_done = 2'b00;
        step();
    endtask

    task automatic test_simultaneous();
        start_btn = 1'b1;
        step();
        start_btn = 1'b0;
        step();
        cnt_done  = 2'b01;
        pause_btn = 1'b1;
        step();
        checks++;
        if ({go, pause, paused, running, active_idx} !== {2'b10, 2'b00, 1'b0, 1'b1, 3'd1}) begin
            errors++;
            $display("FAIL simul_done_wins got go=%b pause=%b pd=%b run=%b idx=%0d exp go=10 pause=00 pd=0 run=1 idx=1",
                     go, pause, paused, running, active_idx);
        end
        pause_btn = 1'b0;
        step();
        checks++;
        if ({pause, paused} !== 3'b000) begin
            errors++;
            $display("FAIL simul_pause_dropped got pause=%b pd=%b exp 0", pause, paused);
        end
        cnt_done = 2'b11;
        step();
        cnt_done = 2'b00;
        step();
    endtask

    task automatic test_loop();
        l_start = 1'b1;
        step();
        checks++;
        if ({l_go, l_running} !== 3'b011) begin
            errors++;
            $display("FAIL loop_start got go=%b run=%b exp go=01 run=1", l_go, l_running);
        end
        l_start = 1'b0;
        l_done  = 2'b01;
        step();
        checks++;
        if (l_go !== 2'b10) begin
            errors++;
            $display("FAIL loop_go1 got=%b exp=10", l_go);
        end
        l_done = 2'b11;
        step();
        checks++;
        if ({l_go, l_laps, l_idx, l_seq_done, l_running} !== {2'b01, 8'd1, 3'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL loop_wrap got go=%b laps=%0d idx=%0d sd=%b run=%b exp go=01 laps=1 idx=0 sd=0 run=1",
                     l_go, l_laps, l_idx, l_seq_done, l_running);
        end
        step();
        checks++;
        if (l_go !== 2'b00) begin
            errors++;
            $display("FAIL loop_stale got=%b exp=00", l_go);
        end
        l_done = 2'b00;
        step();
        l_done = 2'b01;
        step();
        checks++;
        if ({l_go, l_laps} !== {2'b10, 8'd1}) begin
            errors++;
            $display("FAIL loop_second_pass got go=%b laps=%0d exp go=10 laps=1", l_go, l_laps);
        end
    endtask

    task automatic test_reset_mid();
        start_btn = 1'b1;
        step();
        start_btn = 1'b0;
        pause_btn = 1'b1;
        step();
        pause_btn = 1'b0;
        checks++;
        if (paused !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_paused got=%b exp=1", paused);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({tick, go, pause, active_idx, running, paused, seq_done, laps} !== 20'h0) begin
            errors++;
            $display("FAIL rstmid_outputs got=%h exp=0",
                     {tick, go, pause, active_idx, running, paused, seq_done, laps});
        end
        checks++;
        if ({l_laps, l_running, l_idx} !== 12'h0) begin
            errors++;
            $display("FAIL rstmid_loop got laps=%0d run=%b idx=%0d exp 0", l_laps, l_running, l_idx);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        start_btn = 1'b1;
        step();
        checks++;
        if ({go, active_idx, running} !== {2'b01, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL rstmid_restart got go=%b idx=%0d run=%b exp go=01 idx=0 run=1",
                     go, active_idx, running);
        end
        start_btn = 1'b0;
        step();
    endtask

    initial begin
        rst       = 1'b1;
        start_btn = 1'b0;
        pause_btn = 1'b0;
        cnt_done  = 2'b00;
        cnt_out   = 8'h00;
        l_start   = 1'b0;
        l_pause   = 1'b0;
        l_done    = 2'b00;
        l_out     = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_tick();
        test_start();
        test_chain();
        test_stale_done();
        test_pause();
        test_simultaneous();
        test_loop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
